mips_reg_file: RTL and testbench
================================

Name: mips_reg_file

Overview:
- 32 x 32-bit general-purpose register file for the single-cycle MIPS datapath.
- Consumes the A3 destination index from the RegDst mux, WD3 from the writeback mux, and WE3 (RegWrite) from the control unit.
- Supplies RD1/RD2 operands to the ALU-source logic and the data-memory write-data path.
- Also produces a commit-trace interface (write pulse, last address/data, commit counter) for the verification scoreboard.

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- CNT_W, 32, width of the commit counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- A1  input  ADDR_W  read port 1 index (rs field, instr[25:21]).
- A2  input  ADDR_W  read port 2 index (rt field, instr[20:16]).
- A3  input  ADDR_W  write index (output of the RegDst mux).
- WE3  input  1  write enable (RegWrite).
- WD3  input  DATA_W  write data (writeback mux output).
- RD1  output  DATA_W  read data for A1.
- RD2  output  DATA_W  read data for A2.
- wr_commit  output  1  one-cycle pulse: a write committed on the previous edge.
- last_wr_addr  output  ADDR_W  index of the most recent committed write.
- last_wr_data  output  DATA_W  data of the most recent committed write.
- commit_cnt  output  CNT_W  running count of committed writes.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset assertion (any time, including mid-cycle) immediately clears:
  - all 32 registers, so RD1 = RD2 = 0;
  - wr_commit, last_wr_addr, last_wr_data and commit_cnt, all to 0.
- Reset release is synchronised by the environment. There are no internal reset synchronisers.
- Reads:
  - Combinational, zero latency: RD1 = reg[A1], RD2 = reg[A2].
  - Index 0 always reads 0.
- Writes:
  - On the rising edge with WE3 = 1 and A3 != 0: reg[A3] <= WD3.
  - The new value is visible on RD1/RD2 after the edge (single-cycle semantics).
- Register 0 is hardwired to zero. WE3 = 1 with A3 = 0 is dropped:
  - no storage change;
  - no wr_commit pulse;
  - no commit_cnt increment.
- Trace interface, updated on the rising edge:
  - wr_commit <= WE3 && (A3 != 0).
  - When the write commits: last_wr_addr <= A3, last_wr_data <= WD3, commit_cnt <= commit_cnt + 1.
  - commit_cnt wraps modulo 2**CNT_W with no saturation and no flag.
  - last_wr_addr and last_wr_data hold their values between commits.
- Simultaneous read and write of the same index in one cycle: without the optional feature, RD returns the old value until the edge.
- X-handling: if WE3 is X, the write is treated as not taken. An assertion in the bench flags this case.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-through forwarding. When WE3 = 1, A3 != 0 and A1 == A3, RD1 = WD3 combinationally in the same cycle; RD2 follows the same rule with A2. This supports a future pipelined variant.
- Undefined: no forwarding; reads reflect stored state only (behaviour as above).
- In both builds, index 0 always reads 0.

Decomposition:
- Package mips_pkg holds:
  - DATA_W, ADDR_W and NUM_REGS constants;
  - the REG_ZERO index constant;
  - typedef word_t (logic [DATA_W-1:0]);
  - typedef reg_idx_t (logic [ADDR_W-1:0]).
- One sub-module is natural: mips_reg_read_port, the combinational read path including the zero check and the optional bypass. It is instantiated twice, once for A1/RD1 and once for A2/RD2.
- The storage array and the trace logic stay in the top module.

Test Plan:
- Reset: drive rst_n low mid-cycle after several writes -> RD1/RD2 read 0 for every index; commit_cnt = 0; wr_commit = 0 immediately, without waiting for a clock edge.
- Basic write/read: WE3 = 1, A3 = 8, WD3 = 0xDEADBEEF, one edge; then A1 = 8 -> RD1 = 0xDEADBEEF, wr_commit = 1 for exactly one cycle, last_wr_addr = 8, commit_cnt = 1.
- R0 protection: WE3 = 1, A3 = 0, WD3 = 0xFFFFFFFF -> RD1 with A1 = 0 stays 0; wr_commit stays 0; commit_cnt unchanged.
- Same-cycle read/write of reg 9 (old 0x1, WD3 = 0x2):
  - with bypass undefined -> RD2 = 0x1 before the edge, 0x2 after;
  - with REG_FILE_BYPASS_EN defined -> RD2 = 0x2 before the edge.
- Dual read and full sweep: write reg[i] = i*0x01010101 for i = 1..31; then read A1 = i, A2 = 31-i -> both match the written values; commit_cnt = 31.
- Counter wrap: build with CNT_W = 4 and perform 17 commits -> commit_cnt = 1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS register file slice.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/mips_reg_read_port.sv
// Combinational read port: selects one register, forces index 0 to zero and,
// when REG_FILE_BYPASS_EN is defined, forwards same-cycle write data.
module mips_reg_read_port #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs_i,
  input  logic [ADDR_W-1:0]                addr_i,
`ifdef REG_FILE_BYPASS_EN
  input  logic                             wr_en_i,
  input  logic [ADDR_W-1:0]                wr_addr_i,
  input  logic [DATA_W-1:0]                wr_data_i,
`endif
  output logic [DATA_W-1:0]                data_o
);
  import mips_pkg::*;

  // The zero check comes last so it overrides any forwarded value.
  always_comb begin
    data_o = regs_i[addr_i];
`ifdef REG_FILE_BYPASS_EN
    if (wr_en_i && (wr_addr_i == addr_i)) begin
      data_o = wr_data_i;
    end
`endif
    if (addr_i == ADDR_W'(REG_ZERO)) begin
      data_o = '0;
    end
  end

endmodule

// File: rtl/mips_reg_file.sv
// 32 x 32 MIPS register file with a commit-trace port for the scoreboard.
// Optional write-through forwarding is enabled by defining REG_FILE_BYPASS_EN.
module mips_reg_file #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic              WE3,
  input  logic [DATA_W-1:0] WD3,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              wr_commit,
  output logic [ADDR_W-1:0] last_wr_addr,
  output logic [DATA_W-1:0] last_wr_data,
  output logic [CNT_W-1:0]  commit_cnt
);
  import mips_pkg::*;

  localparam int Depth = 2 ** ADDR_W;

  logic [Depth-1:0][DATA_W-1:0] regs_q;
  logic                         wr_commit_q;
  logic [ADDR_W-1:0]            last_addr_q;
  logic [DATA_W-1:0]            last_data_q;
  logic [CNT_W-1:0]             cnt_q;
  logic [CNT_W-1:0]             cnt_d;
  logic                         commit;

  // An unknown WE3 falls into the default branch, so the write is not taken.
  always_comb begin
    commit = 1'b0;
    if (WE3 && (A3 != ADDR_W'(REG_ZERO))) begin
      commit = 1'b1;
    end
    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q      <= '0;
      wr_commit_q <= 1'b0;
      last_addr_q <= '0;
      last_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      wr_commit_q <= commit;
      if (commit) begin
        regs_q[A3]  <= WD3;
        last_addr_q <= A3;
        last_data_q <= WD3;
        cnt_q       <= cnt_d;
      end
    end
  end

  mips_reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .regs_i    (regs_q),
    .addr_i    (A1),
`ifdef REG_FILE_BYPASS_EN
    .wr_en_i   (WE3),
    .wr_addr_i (A3),
    .wr_data_i (WD3),
`endif
    .data_o    (RD1)
  );

  mips_reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .regs_i    (regs_q),
    .addr_i    (A2),
`ifdef REG_FILE_BYPASS_EN
    .wr_en_i   (WE3),
    .wr_addr_i (A3),
    .wr_data_i (WD3),
`endif
    .data_o    (RD2)
  );

  assign wr_commit    = wr_commit_q;
  assign last_wr_addr = last_addr_q;
  assign last_wr_data = last_data_q;
  assign commit_cnt   = cnt_q;

endmodule

// File: tb/tb_mips_reg_file.sv
// Directed bench for mips_reg_file; a second instance with a 4-bit commit
// counter shares the stimulus to exercise counter wrap.
module tb_mips_reg_file;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  A1    = '0;
  logic [4:0]  A2    = '0;
  logic [4:0]  A3    = '0;
  logic        WE3   = 1'b0;
  logic [31:0] WD3   = '0;
  logic [31:0] RD1, RD2;
  logic        wr_commit;
  logic [4:0]  last_wr_addr;
  logic [31:0] last_wr_data;
  logic [31:0] commit_cnt;

  logic [31:0] smRd1, smRd2, smLastData;
  logic        smCommit;
  logic [4:0]  smLastAddr;
  logic [3:0]  smCnt;

  int checks   = 0;
  int failures = 0;

  mips_reg_file dut (
    .clk(clk), .rst_n(rst_n), .A1(A1), .A2(A2), .A3(A3), .WE3(WE3), .WD3(WD3),
    .RD1(RD1), .RD2(RD2), .wr_commit(wr_commit), .last_wr_addr(last_wr_addr),
    .last_wr_data(last_wr_data), .commit_cnt(commit_cnt)
  );

  mips_reg_file #(.CNT_W(4)) dutSmall (
    .clk(clk), .rst_n(rst_n), .A1(A1), .A2(A2), .A3(A3), .WE3(WE3), .WD3(WD3),
    .RD1(smRd1), .RD2(smRd2), .wr_commit(smCommit), .last_wr_addr(smLastAddr),
    .last_wr_data(smLastData), .commit_cnt(smCnt)
  );

  always #5 clk = ~clk;

  // An unknown write enable is dropped by the design; flag it loudly here.
  always @(posedge clk) begin
    assert (!(rst_n && $isunknown(WE3)))
      else $error("[TB] WE3 is unknown at a clock edge");
  end

  // Drive one write; returns at the falling edge after the commit edge.
  task automatic do_write(input logic [4:0] idx, input logic [31:0] data);
    @(negedge clk);
    WE3 = 1'b1; A3 = idx; WD3 = data;
    @(negedge clk);
    WE3 = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    A1 = 5'd7; A2 = 5'd31;
    #1;
    checks++; if (RD1 !== 32'h0) begin failures++; $display("[TB] FAIL reset_rd1: got %h expected %h", RD1, 32'h0); end
    checks++; if (RD2 !== 32'h0) begin failures++; $display("[TB] FAIL reset_rd2: got %h expected %h", RD2, 32'h0); end
    checks++; if (wr_commit !== 1'b0) begin failures++; $display("[TB] FAIL reset_commit: got %b expected 0", wr_commit); end
    checks++; if (commit_cnt !== 32'd0) begin failures++; $display("[TB] FAIL reset_cnt: got %0d expected 0", commit_cnt); end
    checks++; if (last_wr_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_last_data: got %h expected 0", last_wr_data); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_write(5'd8, 32'hDEADBEEF);
    A1 = 5'd8;
    #1;
    checks++; if (RD1 !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL basic_rd1: got %h expected %h", RD1, 32'hDEADBEEF); end
    checks++; if (wr_commit !== 1'b1) begin failures++; $display("[TB] FAIL basic_commit_pulse: got %b expected 1", wr_commit); end
    checks++; if (last_wr_addr !== 5'd8) begin failures++; $display("[TB] FAIL basic_last_addr: got %0d expected 8", last_wr_addr); end
    checks++; if (last_wr_data !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL basic_last_data: got %h expected %h", last_wr_data, 32'hDEADBEEF); end
    checks++; if (commit_cnt !== 32'd1) begin failures++; $display("[TB] FAIL basic_cnt: got %0d expected 1", commit_cnt); end
    @(negedge clk);
    #1;
    checks++; if (wr_commit !== 1'b0) begin failures++; $display("[TB] FAIL basic_commit_single: got %b expected 0", wr_commit); end
    checks++; if (last_wr_addr !== 5'd8) begin failures++; $display("[TB] FAIL basic_last_addr_hold: got %0d expected 8", last_wr_addr); end
  endtask

  task automatic test_r0();
    do_write(5'd0, 32'hFFFFFFFF);
    A1 = 5'd0;
    #1;
    checks++; if (RD1 !== 32'h0) begin failures++; $display("[TB] FAIL r0_rd1: got %h expected 0", RD1); end
    checks++; if (wr_commit !== 1'b0) begin failures++; $display("[TB] FAIL r0_commit: got %b expected 0", wr_commit); end
    checks++; if (commit_cnt !== 32'd1) begin failures++; $display("[TB] FAIL r0_cnt: got %0d expected 1", commit_cnt); end
    checks++; if (last_wr_data !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL r0_last_data: got %h expected %h", last_wr_data, 32'hDEADBEEF); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] expBefore;
`ifdef REG_FILE_BYPASS_EN
    expBefore = 32'h2;
`else
    expBefore = 32'h1;
`endif
    do_write(5'd9, 32'h1);
    WE3 = 1'b1; A3 = 5'd9; WD3 = 32'h2; A2 = 5'd9;
    #1;
    checks++; if (RD2 !== expBefore) begin failures++; $display("[TB] FAIL same_cycle_before: got %h expected %h", RD2, expBefore); end
    @(negedge clk);
    WE3 = 1'b0;
    #1;
    checks++; if (RD2 !== 32'h2) begin failures++; $display("[TB] FAIL same_cycle_after: got %h expected %h", RD2, 32'h2); end
    checks++; if (commit_cnt !== 32'd3) begin failures++; $display("[TB] FAIL same_cycle_cnt: got %0d expected 3", commit_cnt); end
  endtask

  task automatic test_midcycle_reset();
    do_write(5'd5, 32'h55);
    checks++; if (wr_commit !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset_commit: got %b expected 1", wr_commit); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (wr_commit !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_commit: got %b expected 0", wr_commit); end
    checks++; if (commit_cnt !== 32'd0) begin failures++; $display("[TB] FAIL async_reset_cnt: got %0d expected 0", commit_cnt); end
    checks++; if (last_wr_addr !== 5'd0) begin failures++; $display("[TB] FAIL async_reset_last_addr: got %0d expected 0", last_wr_addr); end
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(31 - i);
      #0.1;
      checks++; if ((RD1 | RD2) !== 32'h0) begin failures++; $display("[TB] FAIL async_reset_regs idx %0d: got %h/%h expected 0", i, RD1, RD2); end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back_sweep();
    logic [31:0] exp1, exp2;
    @(negedge clk);
    WE3 = 1'b1;
    for (int i = 1; i < 32; i++) begin
      A3 = 5'(i); WD3 = 32'(i) * 32'h01010101;
      @(negedge clk);
    end
    WE3 = 1'b0;
    #1;
    checks++; if (commit_cnt !== 32'd31) begin failures++; $display("[TB] FAIL sweep_cnt: got %0d expected 31", commit_cnt); end
    checks++; if (smCnt !== 4'd15) begin failures++; $display("[TB] FAIL sweep_small_cnt: got %0d expected 15", smCnt); end
    checks++; if (wr_commit !== 1'b1) begin failures++; $display("[TB] FAIL sweep_commit: got %b expected 1", wr_commit); end
    checks++; if (last_wr_data !== 32'h1F1F1F1F) begin failures++; $display("[TB] FAIL sweep_last_data: got %h expected %h", last_wr_data, 32'h1F1F1F1F); end
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(31 - i);
      exp1 = 32'(i) * 32'h01010101;
      exp2 = 32'(31 - i) * 32'h01010101;
      #1;
      checks++; if (RD1 !== exp1) begin failures++; $display("[TB] FAIL sweep_rd1 idx %0d: got %h expected %h", i, RD1, exp1); end
      checks++; if (RD2 !== exp2) begin failures++; $display("[TB] FAIL sweep_rd2 idx %0d: got %h expected %h", 31 - i, RD2, exp2); end
    end
  endtask

  task automatic test_counter_wrap();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    WE3 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      A3 = 5'((i % 31) + 1); WD3 = 32'(i);
      @(negedge clk);
    end
    WE3 = 1'b0;
    #1;
    checks++; if (smCnt !== 4'd1) begin failures++; $display("[TB] FAIL wrap_small_cnt: got %0d expected 1", smCnt); end
    checks++; if (commit_cnt !== 32'd17) begin failures++; $display("[TB] FAIL wrap_wide_cnt: got %0d expected 17", commit_cnt); end
    checks++; if (smLastAddr !== 5'd17) begin failures++; $display("[TB] FAIL wrap_last_addr: got %0d expected 17", smLastAddr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_r0();
    test_same_cycle();
    test_midcycle_reset();
    test_back_to_back_sweep();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
